// File: rtl/fm0_decoder.sv
// FM0 (bi-phase space) line decoder: locks on the first line edge, samples each
// symbol at its quarter points and emits one data bit per symbol through a ready/valid port.
module fm0_decoder (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sym_period,
    input  logic       in_fm0,
    input  logic       in_vld,
    output logic       out_bit,
    output logic       out_vld,
    input  logic       out_rdy,
    output logic       err_cv,
    output logic       err_ovf,
    output logic       locked
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       prev;
    logic       have_b;
    logic       last_b;
    logic       s_a;
    logic       s_b;

    logic [4:0] qa;
    logic [4:0] qb;
    logic [4:0] p_last;
    logic       p_ok;
    logic       trans;
    logic       at_qa;
    logic       at_qb;
    logic       at_end;
    logic       consume_run;
    logic       sb_now;
    logic       dec_bit;
    logic       produce;
    logic       cv;

    // Sample-point decode and per-sample decisions
    always_comb begin
        qa          = {3'b000, sym_period[3:2]};
        qb          = {2'b00, sym_period[3:1]} + {3'b000, sym_period[3:2]};
        p_last      = {1'b0, sym_period} - 5'd1;
        p_ok        = (sym_period >= 4'd4);
        trans       = (in_fm0 != prev);
        at_qa       = ({1'b0, cnt} == qa);
        at_qb       = ({1'b0, cnt} == qb);
        at_end      = ({1'b0, cnt} == p_last);
        consume_run = in_vld && p_ok && (state == RUN);
        // For P=4 the second sample point coincides with the last sample
        sb_now      = at_qb ? in_fm0 : s_b;
        dec_bit     = (s_a == sb_now);
        cv          = consume_run && at_qa && have_b && (in_fm0 == last_b);
        produce     = consume_run && at_end;
    end

    // Lock FSM, symbol counter, sample capture and output handshake
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            prev    <= 1'b0;
            have_b  <= 1'b0;
            last_b  <= 1'b0;
            s_a     <= 1'b0;
            s_b     <= 1'b0;
            out_bit <= 1'b0;
            out_vld <= 1'b0;
            err_cv  <= 1'b0;
            err_ovf <= 1'b0;
            locked  <= 1'b0;
        end else begin
            err_cv  <= 1'b0;
            err_ovf <= 1'b0;

            if (produce) begin
                if (!out_vld || out_rdy) begin
                    out_bit <= dec_bit;
                    out_vld <= 1'b1;
                end else begin
                    err_ovf <= 1'b1;
                end
            end else if (out_rdy) begin
                out_vld <= 1'b0;
            end

            if (in_vld) begin
                prev <= in_fm0;
                if (!p_ok) begin
                    state  <= IDLE;
                    locked <= 1'b0;
                    cnt    <= 4'd0;
                    have_b <= 1'b0;
                end else begin
                    case (state)
                        IDLE: begin
                            if (trans) begin
                                state  <= RUN;
                                locked <= 1'b1;
                                cnt    <= 4'd1;
                                have_b <= 1'b0;
                            end
                        end
                        RUN: begin
                            if (cv) begin
                                err_cv <= 1'b1;
                                state  <= IDLE;
                                locked <= 1'b0;
                                cnt    <= 4'd0;
                                have_b <= 1'b0;
                            end else begin
                                if (at_qa) s_a <= in_fm0;
                                if (at_qb) s_b <= in_fm0;
                                if (at_end) begin
                                    have_b <= 1'b1;
                                    last_b <= sb_now;
                                    // An edge on the last sample is an early boundary
                                    cnt    <= trans ? 4'd1 : 4'd0;
                                end else if ((cnt == 4'd1) && trans) begin
                                    cnt    <= 4'd1;
                                end else begin
                                    cnt    <= cnt + 4'd1;
                                end
                            end
                        end
                        default: begin
                            state  <= IDLE;
                            locked <= 1'b0;
                            cnt    <= 4'd0;
                            have_b <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_fm0_decoder.sv
// Directed bench for fm0_decoder: an FM0 encoder task drives the line and a
// negedge monitor records accepted bits and error pulses for comparison.
module tb_fm0_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] sym_period = 4'd8;
    logic       in_fm0 = 1'b0;
    logic       in_vld = 1'b0;
    logic       out_bit;
    logic       out_vld;
    logic       out_rdy = 1'b1;
    logic       err_cv;
    logic       err_ovf;
    logic       locked;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int vld_cycles = 0;
    int cv_cnt  = 0;
    int ovf_cnt = 0;
    int acc_bits[$];
    int acc_cyc[$];
    logic lvl  = 1'b0;
    logic gap  = 1'b0;

    fm0_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .sym_period (sym_period),
        .in_fm0     (in_fm0),
        .in_vld     (in_vld),
        .out_bit    (out_bit),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .err_cv     (err_cv),
        .err_ovf    (err_ovf),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (rst) begin
            if (out_vld) vld_cycles = vld_cycles + 1;
            if (out_vld && out_rdy) begin
                acc_bits.push_back(int'(out_bit));
                acc_cyc.push_back(cyc);
            end
            if (err_cv) cv_cnt = cv_cnt + 1;
            if (err_ovf) ovf_cnt = ovf_cnt + 1;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_chk = n_chk + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        vld_cycles = 0;
        cv_cnt     = 0;
        ovf_cnt    = 0;
        acc_bits.delete();
        acc_cyc.delete();
    endtask

    task automatic do_reset();
        rst    = 1'b0;
        in_vld = 1'b0;
        in_fm0 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        lvl = 1'b0;
        clear_mon();
    endtask

    task automatic idle(input int n);
        in_vld = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_sample(input logic b);
        in_fm0 = b;
        in_vld = 1'b1;
        @(posedge clk);
        #1;
        if (gap) begin
            in_vld = 1'b0;
            @(posedge clk);
            #1;
        end
        in_vld = 1'b0;
    endtask

    // One FM0 symbol of len samples: edge at start, mid edge for a 0
    task automatic send_sym(input logic b, input int len);
        lvl = ~lvl;
        for (int i = 0; i < 4; i++) send_sample(lvl);
        if (!b) lvl = ~lvl;
        for (int i = 4; i < len; i++) send_sample(lvl);
    endtask

    task automatic preamble();
        for (int i = 0; i < 3; i++) send_sample(1'b0);
    endtask

    function automatic int packed_bits();
        int v = 0;
        foreach (acc_bits[i]) v = (v << 1) | acc_bits[i];
        return v;
    endfunction

    function automatic int bad_spacing(input int sp);
        int bad = 0;
        for (int i = 1; i < acc_cyc.size(); i++)
            if (acc_cyc[i] - acc_cyc[i-1] != sp) bad = bad + 1;
        return bad;
    endfunction

    initial begin
        // Reset state
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_out_vld", int'(out_vld), 0);
        check("rst_out_bit", int'(out_bit), 0);
        check("rst_err_cv",  int'(err_cv), 0);
        check("rst_err_ovf", int'(err_ovf), 0);
        check("rst_locked",  int'(locked), 0);
        rst = 1'b1;

        // Basic decode 1,0,1,1,0
        do_reset();
        preamble();
        send_sym(1'b1, 8);
        check("lock_after_edge", int'(locked), 1);
        send_sym(1'b0, 8);
        send_sym(1'b1, 8);
        send_sym(1'b1, 8);
        send_sym(1'b0, 8);
        idle(3);
        check("basic_count", acc_bits.size(), 5);
        check("basic_bits", packed_bits(), 22);
        check("basic_spacing", bad_spacing(8), 0);
        check("basic_vld_cycles", vld_cycles, 5);
        check("basic_no_cv", cv_cnt, 0);

        // Missing boundary edge -> code violation at cnt==2
        clear_mon();
        send_sample(lvl);
        send_sample(lvl);
        check("cv_not_early", int'(err_cv), 0);
        send_sample(lvl);
        check("cv_pulse", int'(err_cv), 1);
        check("cv_unlock", int'(locked), 0);
        idle(3);
        check("cv_one_cycle", cv_cnt, 1);
        check("cv_no_bit", acc_bits.size(), 0);

        // Overflow: first bit held, second dropped
        do_reset();
        out_rdy = 1'b0;
        preamble();
        send_sym(1'b0, 8);
        send_sym(1'b1, 8);
        check("ovf_pulse", int'(err_ovf), 1);
        idle(1);
        check("ovf_one_cycle", int'(err_ovf), 0);
        check("ovf_held_vld", int'(out_vld), 1);
        check("ovf_held_bit", int'(out_bit), 0);
        out_rdy = 1'b1;
        idle(3);
        check("ovf_release_count", acc_bits.size(), 1);
        check("ovf_release_bit", packed_bits(), 0);
        check("ovf_count", ovf_cnt, 1);
        check("ovf_vld_clear", int'(out_vld), 0);

        // in_vld toggling: same bits, 16-clk spacing
        do_reset();
        gap = 1'b1;
        preamble();
        send_sym(1'b1, 8);
        send_sym(1'b0, 8);
        send_sym(1'b1, 8);
        send_sym(1'b1, 8);
        send_sym(1'b0, 8);
        gap = 1'b0;
        idle(3);
        check("gap_count", acc_bits.size(), 5);
        check("gap_bits", packed_bits(), 22);
        check("gap_spacing", bad_spacing(16), 0);
        check("gap_no_cv", cv_cnt, 0);

        // Phase jitter: one early boundary, one late boundary
        do_reset();
        preamble();
        send_sym(1'b1, 8);
        send_sym(1'b0, 7);
        send_sym(1'b1, 8);
        send_sym(1'b1, 9);
        send_sym(1'b0, 8);
        idle(3);
        check("jit_count", acc_bits.size(), 5);
        check("jit_bits", packed_bits(), 22);
        check("jit_no_cv", cv_cnt, 0);

        // Reset mid-symbol with a held bit
        do_reset();
        out_rdy = 1'b0;
        preamble();
        send_sym(1'b1, 8);
        lvl = ~lvl;
        for (int i = 0; i < 3; i++) send_sample(lvl);
        check("mid_held_vld", int'(out_vld), 1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_vld", int'(out_vld), 0);
        check("mid_rst_bit", int'(out_bit), 0);
        check("mid_rst_cv",  int'(err_cv), 0);
        check("mid_rst_ovf", int'(err_ovf), 0);
        check("mid_rst_lock", int'(locked), 0);
        rst = 1'b1;
        out_rdy = 1'b1;
        lvl = 1'b0;
        clear_mon();
        preamble();
        check("mid_no_early_bit", acc_bits.size(), 0);
        send_sym(1'b0, 8);
        send_sym(1'b1, 8);
        idle(3);
        check("relock_count", acc_bits.size(), 2);
        check("relock_bits", packed_bits(), 1);
        check("relock_no_cv", cv_cnt, 0);

        // Unsupported period stays idle
        do_reset();
        sym_period = 4'd3;
        preamble();
        send_sym(1'b1, 8);
        send_sym(1'b0, 8);
        check("p3_locked", int'(locked), 0);
        idle(2);
        check("p3_no_bits", acc_bits.size(), 0);
        check("p3_no_cv", cv_cnt, 0);
        sym_period = 4'd8;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fm0_decoder.md
FM0_DECODER -- requirements
Module: fm0_decoder

Interface
REQ-001 SHALL have the following ports, each listed as name  direction  width  meaning; clock and reset come first:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  reset; synchronous and active-low.
- sym_period  input  4  samples per FM0 symbol (P).
- in_fm0  input  1  line sample.
- in_vld  input  1  in_fm0 qualifier; one sample consumed per clk with in_vld=1.
- out_bit  output  1  decoded data bit.
- out_vld  output  1  out_bit valid.
- out_rdy  input  1  downstream accepts out_bit.
- err_cv  output  1  one-cycle pulse on FM0 code violation.
- err_ovf  output  1  one-cycle pulse when a decoded bit is dropped.
- locked  output  1  high while state is RUN.

REQ-002 SHALL be valid only for P in 4..15; for P<4 the block SHALL remain in IDLE with no outputs asserted.

Function
REQ-003 SHALL consume samples and advance counters/state only on cycles with in_vld=1; out_rdy handshake SHALL operate every cycle regardless of in_vld.
REQ-004 SHALL keep prev, the last consumed sample; a transition is a consumed sample != prev.
REQ-005 SHALL have states IDLE and RUN; locked=1 exactly in RUN.
REQ-006 IDLE: on the first transition SHALL set cnt<=1 and have_b<=0, and go to RUN; that transition sample is symbol sample 0.
REQ-007 RUN: cnt SHALL count 0..P-1 per consumed sample and wrap to 0 after P-1.
REQ-008 SHALL use QA = P>>2 and QB = (P>>1)+(P>>2), computed in at least 5 bits without overflow.
REQ-009 SHALL capture s_a at cnt==QA and s_b at cnt==QB.
REQ-010 At cnt==P-1 SHALL produce bit = (s_a==s_b): data-1 has no mid-symbol transition, data-0 has one; SHALL then set have_b<=1 and last_b<=s_b.
REQ-011 Boundary check: at cnt==QA with have_b=1, if the new s_a == last_b (missing boundary transition), SHALL pulse err_cv, discard the symbol in progress, and return to IDLE.
REQ-012 Resync, early: a transition with cnt==P-1 SHALL complete the symbol as REQ-010, with that sample taken as sample 0 of the next symbol (cnt<=1).
REQ-013 Resync, late: a transition with cnt==1 SHALL hold cnt at 1 for that sample; it SHALL NOT be treated as a data transition.
REQ-014 Output: when a bit is produced and (out_vld==0 or out_rdy==1 in the same cycle), SHALL load out_bit and set out_vld=1 next cycle.
REQ-015 Output: when a bit is produced while out_vld==1 and out_rdy==0, SHALL keep the held bit, drop the new bit and pulse err_ovf.
REQ-016 out_vld SHALL clear on out_rdy=1 unless reloaded the same cycle; out_bit SHALL be stable while out_vld=1 and out_rdy=0.
REQ-017 Decode latency SHALL be 1 clk from the consumed sample at cnt==P-1 to out_vld.
REQ-018 A code violation and a bit production SHALL never coincide (QA < P-1 for P>=4); if err_cv and err_ovf both fire in one cycle, both SHALL be reported.
REQ-019 A change of sym_period mid-stream is undefined; the block SHALL re-lock after any err_cv.

Reset
REQ-020 With rst=0 at a clk edge, the next-state values SHALL be: state IDLE, cnt 0, prev 0, have_b 0, out_vld 0, out_bit 0, err_cv 0, err_ovf 0, locked 0.
REQ-021 Reset mid-symbol or with out_vld=1 SHALL discard all partial and held data; no bit SHALL be emitted afterwards until a new lock.

Verification
REQ-022 P=8, in_vld=1, out_rdy=1; preamble edge then FM0 bits 1,0,1,1,0 -> out_bit sequence 1,0,1,1,0, each out_vld one cycle, 8 clks apart, err_cv never asserted.
REQ-023 P=8 locked; hold the line level across a symbol boundary -> err_cv pulse at the next cnt==2 sample, locked=0, no bit emitted for that symbol.
REQ-024 P=8, out_rdy=0 during two decoded bits -> first bit held stable, second dropped with err_ovf=1 for one cycle; out_rdy=1 then releases only the first bit.
REQ-025 P=8 with in_vld toggling 1,0,1,0 -> same decoded bits as REQ-022, symbol spacing 16 clks.
REQ-026 Phase jitter: with P=8, one boundary edge arriving one sample early and a later one arriving one sample late -> no err_cv and all bits correct.
REQ-027 rst=0 for one cycle mid-symbol with out_vld=1 -> all outputs 0 next cycle; the block re-locks on the next transition and decodes correctly.
